// File: rtl/booth_mul_arbiter.sv
// Round-robin front end sharing one pipelined 8x8 signed multiplier
// datapath among N_REQ requesters.
// - Up to one operand pair is issued into the datapath per cycle.
// - The owner's ID travels down a tag pipeline that matches the datapath
//   latency, so each product goes back to the requester that issued it.
// - Results come back as a one-cycle tagged pulse, with no backpressure.
module booth_mul_arbiter #(
    parameter int N_REQ = 4,
    parameter int LAT   = 3,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] a_in,
    input  logic [8*N_REQ-1:0] b_in,
    output logic [N_REQ-1:0]   gnt,
    output logic               mul_ld,
    output logic [7:0]         mul_a,
    output logic [7:0]         mul_b,
    input  logic [15:0]        mul_p,
    output logic               res_valid,
    output logic [IDW-1:0]     res_id,
    output logic [15:0]        res_data,
    output logic               busy
);

    // round-robin pointer and current winner
    logic [IDW-1:0]          ptr_q, ptr_d;
    logic [IDW-1:0]          win_id;
    logic                    win_found;
    logic [IDW:0]            cand;
    logic                    xfer;

    // operands selected from the winner
    logic [7:0]              a_sel, b_sel;

    // issue register
    logic                    mul_ld_q, mul_ld_d;
    logic [7:0]              mul_a_q, mul_a_d;
    logic [7:0]              mul_b_q, mul_b_d;

    // tag pipeline: stage j is valid in cycle k+1+j for a transfer at edge k
    logic [LAT:0]            tag_vld_q, tag_vld_d;
    logic [LAT:0][IDW-1:0]   tag_id_q, tag_id_d;

    // result register
    logic                    res_valid_q, res_valid_d;
    logic [IDW-1:0]          res_id_q, res_id_d;
    logic [15:0]             res_data_q, res_data_d;

    // Pick the first active request at or after ptr (mod N_REQ).
    // The scan runs from the far end back toward ptr, so the last hit
    // is the nearest one.
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N_REQ)) begin
                cand = cand - (IDW+1)'(N_REQ);
            end
            if (req[cand[IDW-1:0]]) begin
                win_id    = cand[IDW-1:0];
                win_found = 1'b1;
            end
        end
    end

    // One-hot grant.
    // The grant is suppressed while reset is asserted, so no transfer can
    // land on the reset edge.
    always_comb begin
        gnt = '0;
        if (win_found && en && reset) begin
            gnt[win_id] = 1'b1;
        end
    end

    assign xfer = |gnt;

    // Route the winner's operand pair toward the issue register
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == IDW'(i)) begin
                a_sel = a_in[8*i +: 8];
                b_sel = b_in[8*i +: 8];
            end
        end
    end

    // Next-state logic: pointer advance, issue capture, tag shift, result capture
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + 1'b1;
        end

        mul_ld_d = xfer;
        mul_a_d  = xfer ? a_sel : mul_a_q;
        mul_b_d  = xfer ? b_sel : mul_b_q;

        tag_vld_d   = {tag_vld_q[LAT-1:0], xfer};
        tag_id_d    = tag_id_q;
        tag_id_d[0] = win_id;
        for (int j = 1; j <= LAT; j++) begin
            tag_id_d[j] = tag_id_q[j-1];
        end

        // the last tag stage lines up with the datapath output
        res_valid_d = tag_vld_q[LAT];
        res_id_d    = tag_vld_q[LAT] ? tag_id_q[LAT] : res_id_q;
        res_data_d  = tag_vld_q[LAT] ? mul_p         : res_data_q;
    end

    // State registers.
    // A synchronous reset clears everything, which drops any in-flight tags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q       <= '0;
            mul_ld_q    <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            mul_ld_q    <= mul_ld_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
        end
    end

    assign mul_ld    = mul_ld_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;
    assign busy      = (|tag_vld_q) | res_valid_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed and randomized bench for booth_mul_arbiter.
// The bench also contains a behavioural LAT-stage multiplier that stands
// in for the shared datapath.
module tb_booth_mul_arbiter;

    localparam int N_REQ = 4;
    localparam int LAT   = 3;
    localparam int IDW   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] a_in;
    logic [8*N_REQ-1:0] b_in;
    logic [N_REQ-1:0]   gnt;
    logic               mul_ld;
    logic [7:0]         mul_a;
    logic [7:0]         mul_b;
    logic [15:0]        mul_p;
    logic               res_valid;
    logic [IDW-1:0]     res_id;
    logic [15:0]        res_data;
    logic               busy;

    logic [7:0]         a_op [N_REQ];
    logic [7:0]         b_op [N_REQ];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    // pack per-requester operands onto the flat buses
    always_comb begin
        a_in = '0;
        b_in = '0;
        for (int i = 0; i < N_REQ; i++) begin
            a_in[8*i +: 8] = a_op[i];
            b_in[8*i +: 8] = b_op[i];
        end
    end

    // datapath model; it drives a poison value whenever no product is valid
    logic [15:0] dp_p [LAT];
    logic        dp_v [LAT];
    always @(posedge clk) begin
        dp_v[0] <= mul_ld;
        dp_p[0] <= $signed(mul_a) * $signed(mul_b);
        for (int i = 1; i < LAT; i++) begin
            dp_v[i] <= dp_v[i-1];
            dp_p[i] <= dp_p[i-1];
        end
    end
    assign mul_p = dp_v[LAT-1] ? dp_p[LAT-1] : 16'hDEAD;

    booth_mul_arbiter #(.N_REQ(N_REQ), .LAT(LAT), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .mul_ld    (mul_ld),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_data  (res_data),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        en    = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        en    = 1'b1;
        req   = '1;
        for (int i = 0; i < N_REQ; i++) begin
            a_op[i] = 8'h01;
            b_op[i] = 8'h01;
        end
        tick();
        tick();
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        n_tests++; if (mul_ld !== 1'b0) begin n_fail++; $display("FAIL reset_mul_ld: got %b expected 0", mul_ld); end
        n_tests++; if (mul_a !== 8'h00 || mul_b !== 8'h00) begin n_fail++; $display("FAIL reset_mul_ab: got %h/%h expected 00/00", mul_a, mul_b); end
        n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        n_tests++; if (res_id !== 2'd0 || res_data !== 16'h0000) begin n_fail++; $display("FAIL reset_res: got id %0d data %h expected 0/0000", res_id, res_data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        req   = '0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        apply_reset();
        a_op[0] = 8'hFD;
        b_op[0] = 8'h05;
        req     = 4'b0001;
        #1;
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
        tick();
        req = '0;
        n_tests++; if (mul_ld !== 1'b1 || mul_a !== 8'hFD || mul_b !== 8'h05) begin n_fail++; $display("FAIL single_issue: got ld %b a %h b %h expected 1 FD 05", mul_ld, mul_a, mul_b); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
        for (int i = 0; i <= LAT; i++) begin
            n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_res: cycle %0d got %b expected 0", i, res_valid); end
            if (i > 0) begin
                n_tests++; if (mul_ld !== 1'b0) begin n_fail++; $display("FAIL single_ld_pulse: cycle %0d got %b expected 0", i, mul_ld); end
            end
            tick();
        end
        n_tests++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 16'hFFF1) begin n_fail++; $display("FAIL single_result: got v %b id %0d data %h expected 1 0 FFF1", res_valid, res_id, res_data); end
        tick();
        n_tests++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_after: got v %b busy %b expected 0 0", res_valid, busy); end
        n_tests++; if (mul_a !== 8'hFD) begin n_fail++; $display("FAIL single_hold_a: got %h expected FD", mul_a); end
    endtask

    task automatic test_all_four();
        logic [3:0]  exp_g [4];
        logic [7:0]  exp_a [4];
        logic [15:0] exp_d [4];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_a = '{8'h7F, 8'h80, 8'h00, 8'h07};
        exp_d = '{16'hC080, 16'h4000, 16'h0000, 16'h003F};
        apply_reset();
        a_op[0] = 8'h7F; b_op[0] = 8'h80;
        a_op[1] = 8'h80; b_op[1] = 8'h80;
        a_op[2] = 8'h00; b_op[2] = 8'h37;
        a_op[3] = 8'h07; b_op[3] = 8'h09;
        req = 4'b1111;
        for (int c = 0; c < 4 + LAT + 2; c++) begin
            if (c >= LAT + 2 && c < LAT + 6) begin
                n_tests++; if (res_valid !== 1'b1 || res_id !== IDW'(c - LAT - 2) || res_data !== exp_d[c-LAT-2]) begin n_fail++; $display("FAIL all4_result: slot %0d got v %b id %0d data %h expected 1 %0d %h", c - LAT - 2, res_valid, res_id, res_data, c - LAT - 2, exp_d[c-LAT-2]); end
            end else begin
                n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL all4_idle_res: cycle %0d got %b expected 0", c, res_valid); end
            end
            if (c >= 1 && c <= 4) begin
                n_tests++; if (mul_ld !== 1'b1 || mul_a !== exp_a[c-1]) begin n_fail++; $display("FAIL all4_issue: cycle %0d got ld %b a %h expected 1 %h", c, mul_ld, mul_a, exp_a[c-1]); end
            end
            if (c < 4) begin
                #1;
                n_tests++; if (gnt !== exp_g[c]) begin n_fail++; $display("FAIL all4_gnt: cycle %0d got %b expected %b", c, gnt, exp_g[c]); end
            end
            tick();
            if (c < 4) req[c] = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ta [6];
        logic [7:0]  tb [6];
        logic [15:0] td [6];
        ta = '{8'h0A, 8'hEC, 8'h1E, 8'hD8, 8'h32, 8'hC4};
        tb = '{8'h03, 8'hFC, 8'h05, 8'hFA, 8'h07, 8'hF8};
        td = '{16'h001E, 16'h0050, 16'h0096, 16'h00F0, 16'h015E, 16'h01E0};
        apply_reset();
        for (int c = 0; c < 6 + LAT + 2; c++) begin
            if (c >= LAT + 2 && c < LAT + 8) begin
                n_tests++; if (res_valid !== 1'b1 || res_id !== 2'd2 || res_data !== td[c-LAT-2]) begin n_fail++; $display("FAIL b2b_result: slot %0d got v %b id %0d data %h expected 1 2 %h", c - LAT - 2, res_valid, res_id, res_data, td[c-LAT-2]); end
            end else begin
                n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_res: cycle %0d got %b expected 0", c, res_valid); end
            end
            if (c >= 1 && c <= 6) begin
                n_tests++; if (mul_ld !== 1'b1 || mul_a !== ta[c-1] || mul_b !== tb[c-1]) begin n_fail++; $display("FAIL b2b_issue: cycle %0d got ld %b a %h b %h expected 1 %h %h", c, mul_ld, mul_a, mul_b, ta[c-1], tb[c-1]); end
            end
            if (c < 6) begin
                a_op[2] = ta[c];
                b_op[2] = tb[c];
                req     = 4'b0100;
                #1;
                n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL b2b_gnt: cycle %0d got %b expected 0100", c, gnt); end
            end else begin
                req = '0;
            end
            tick();
        end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b expected 0", busy); end
    endtask

    task automatic test_en_low();
        apply_reset();
        a_op[0] = 8'h02; b_op[0] = 8'h03;
        a_op[1] = 8'hFC; b_op[1] = 8'h05;
        a_op[2] = 8'h0B; b_op[2] = 8'hF5;
        a_op[3] = 8'hFF; b_op[3] = 8'hFF;
        req = 4'b0011;
        #1;
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL en_gnt0: got %b expected 0001", gnt); end
        tick();
        req[0] = 1'b0;
        #1;
        n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL en_gnt1: got %b expected 0010", gnt); end
        tick();
        req = 4'b1111;
        en  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (res_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL en_low_state: cycle %0d got v %b busy %b expected 0 1", i, res_valid, busy); end
            n_tests++; if (mul_ld !== (i == 0)) begin n_fail++; $display("FAIL en_low_ld: cycle %0d got %b expected %b", i, mul_ld, (i == 0)); end
            #1;
            n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL en_low_gnt: cycle %0d got %b expected 0000", i, gnt); end
            tick();
        end
        en = 1'b1;
        n_tests++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 16'h0006) begin n_fail++; $display("FAIL en_res0: got v %b id %0d data %h expected 1 0 0006", res_valid, res_id, res_data); end
        #1;
        n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL en_resume_gnt: got %b expected 0100", gnt); end
        tick();
        req[2] = 1'b0;
        n_tests++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 16'hFFEC) begin n_fail++; $display("FAIL en_res1: got v %b id %0d data %h expected 1 1 FFEC", res_valid, res_id, res_data); end
        n_tests++; if (mul_ld !== 1'b1 || mul_a !== 8'h0B) begin n_fail++; $display("FAIL en_issue2: got ld %b a %h expected 1 0B", mul_ld, mul_a); end
        #1;
        n_tests++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL en_gnt3: got %b expected 1000", gnt); end
        tick();
        req[3] = 1'b0;
        n_tests++; if (mul_a !== 8'hFF) begin n_fail++; $display("FAIL en_issue3: got %h expected FF", mul_a); end
        #1;
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL en_wrap_gnt: got %b expected 0001", gnt); end
        req = '0;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL en_gap: cycle %0d got %b expected 0", i, res_valid); end
            tick();
        end
        n_tests++; if (res_valid !== 1'b1 || res_id !== 2'd2 || res_data !== 16'hFF87) begin n_fail++; $display("FAIL en_res2: got v %b id %0d data %h expected 1 2 FF87", res_valid, res_id, res_data); end
        tick();
        n_tests++; if (res_valid !== 1'b1 || res_id !== 2'd3 || res_data !== 16'h0001) begin n_fail++; $display("FAIL en_res3: got v %b id %0d data %h expected 1 3 0001", res_valid, res_id, res_data); end
        tick();
        n_tests++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL en_drain: got v %b busy %b expected 0 0", res_valid, busy); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        a_op[1] = 8'h11; b_op[1] = 8'h02;
        req = 4'b0010;
        #1;
        n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rstmid_gnt1: got %b expected 0010", gnt); end
        tick();
        req = '0;
        n_tests++; if (mul_ld !== 1'b1) begin n_fail++; $display("FAIL rstmid_ld: got %b expected 1", mul_ld); end
        tick();
        reset = 1'b0;
        req   = 4'b1000;
        #1;
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rstmid_gnt_in_reset: got %b expected 0000", gnt); end
        tick();
        reset = 1'b1;
        n_tests++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_cleared: got busy %b v %b expected 0 0", busy, res_valid); end
        req = 4'b1010;
        #1;
        n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rstmid_ptr: got %b expected 0010", gnt); end
        req = '0;
        for (int i = 0; i < LAT + 3; i++) begin
            tick();
            n_tests++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_dropped: cycle %0d got v %b busy %b expected 0 0", i, res_valid, busy); end
        end
    endtask

    task automatic test_random();
        int          waits [N_REQ];
        int          exp_id_q [$];
        logic [15:0] exp_p_q [$];
        logic signed [15:0] pe;
        int          w;
        int          e_id;
        logic [15:0] e_p;
        logic        did_xfer;
        apply_reset();
        for (int i = 0; i < N_REQ; i++) waits[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            if (res_valid) begin
                n_tests++;
                if (exp_id_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_unexpected: cycle %0d got id %0d data %h expected no result", c, res_id, res_data);
                end else begin
                    e_id = exp_id_q.pop_front();
                    e_p  = exp_p_q.pop_front();
                    if (res_id !== IDW'(e_id) || res_data !== e_p) begin n_fail++; $display("FAIL rand_result: cycle %0d got id %0d data %h expected %0d %h", c, res_id, res_data, e_id, e_p); end
                end
            end
            en = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i] && ($urandom_range(0, 1) == 1)) begin
                    req[i]  = 1'b1;
                    a_op[i] = 8'($urandom_range(0, 255));
                    b_op[i] = 8'($urandom_range(0, 255));
                end
            end
            #1;
            n_tests++; if (((gnt & (gnt - 4'd1)) != 4'd0) || ((gnt & ~req) != 4'd0)) begin n_fail++; $display("FAIL rand_onehot: cycle %0d got gnt %b req %b", c, gnt, req); end
            n_tests++; if ((gnt != 4'd0) !== (en && (req != 4'd0))) begin n_fail++; $display("FAIL rand_gnt_active: cycle %0d got gnt %b expected nonzero=%b", c, gnt, (en && (req != 4'd0))); end
            did_xfer = 1'b0;
            w = 0;
            if (gnt != 4'd0) begin
                did_xfer = 1'b1;
                for (int i = 0; i < N_REQ; i++) if (gnt[i]) w = i;
                pe = $signed(a_op[w]) * $signed(b_op[w]);
                exp_id_q.push_back(w);
                exp_p_q.push_back(pe);
                for (int i = 0; i < N_REQ; i++) begin
                    if (i == w) begin
                        waits[i] = 0;
                    end else if (req[i]) begin
                        waits[i]++;
                        n_tests++; if (waits[i] > N_REQ - 1) begin n_fail++; $display("FAIL rand_fairness: cycle %0d requester %0d got %0d waits expected <= %0d", c, i, waits[i], N_REQ - 1); end
                    end
                end
            end
            tick();
            if (did_xfer) req[w] = 1'b0;
        end
        req = '0;
        for (int c = 0; c < LAT + 4; c++) begin
            if (res_valid) begin
                n_tests++;
                if (exp_id_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_drain_unexpected: got id %0d data %h expected no result", res_id, res_data);
                end else begin
                    e_id = exp_id_q.pop_front();
                    e_p  = exp_p_q.pop_front();
                    if (res_id !== IDW'(e_id) || res_data !== e_p) begin n_fail++; $display("FAIL rand_drain_result: got id %0d data %h expected %0d %h", res_id, res_data, e_id, e_p); end
                end
            end
            tick();
        end
        n_tests++; if (exp_id_q.size() != 0) begin n_fail++; $display("FAIL rand_missing: got %0d results outstanding expected 0", exp_id_q.size()); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_busy: got %b expected 0", busy); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        en    = 1'b1;
        req   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            a_op[i] = '0;
            b_op[i] = '0;
        end
        test_reset();
        test_single();
        test_all_four();
        test_back_to_back();
        test_en_low();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Round-robin front-end that shares one pipelined radix-4 Booth multiplier datapath between N_REQ requesters. Each requester presents a signed 8×8 operand pair with a req/gnt handshake. The arbiter issues at most one product per cycle into the datapath and tracks requester IDs through a tag pipeline matched to the datapath latency. It returns each 16-bit product to its owner as a one-cycle tagged pulse.

## Interface
- N_REQ, 4, number of requesters (2..8)
- LAT, 3, cycles from `mul_ld` high to `mul_p` valid at the datapath output (≥1)
- IDW, $clog2(N_REQ), requester ID width
- clk  in  1  rising-edge clock; sole clock
- reset  in  1  synchronous, active-low reset
- en  in  1  grant enable; low blocks new grants, in-flight ops still drain
- req  in  N_REQ  per-requester request
- a_in  in  8*N_REQ  multiplier operands, slice i = [8i+7:8i], signed
- b_in  in  8*N_REQ  multiplicand operands, same slicing, signed
- gnt  out  N_REQ  one-hot combinational grant
- mul_ld  out  1  registered issue strobe to the datapath
- mul_a  out  8  registered multiplier to the datapath
- mul_b  out  8  registered multiplicand to the datapath
- mul_p  in  16  datapath product, valid LAT cycles after `mul_ld`
- res_valid  out  1  registered result strobe, one cycle
- res_id  out  IDW  owner of `res_data`
- res_data  out  16  signed product a*b
- busy  out  1  high while any operation is in the tag pipeline or at `res_valid`

## Operation
- Transfer: occurs when `req[i] && gnt[i]` is high at a rising edge. The requester holds `a_in`/`b_in` stable while `req` is high and the transfer has not happened.
- `gnt`: combinational. At most one bit is set. It is all-zero when `en=0`, when `reset=0`, or when no `req` is set.
- Arbitration: round-robin pointer `ptr`. The winner is the first set `req` at index ptr, ptr+1, … mod N_REQ. After a transfer to i, `ptr` becomes (i+1) mod N_REQ. With no transfer, `ptr` holds.
- Issue register: captures the winner's operands on the transfer edge. `mul_ld=1` for exactly one cycle per transfer. `mul_a`/`mul_b` hold their last value when `mul_ld=0`.
- Tag pipeline: LAT+1 stages of {valid, id}.
  - Stage 0 loads {transfer, winner} on the transfer edge and shifts every cycle. There is no stall.
  - When the last stage is valid, `res_valid`, `res_id` and `res_data` ← `mul_p` are registered on the next edge.
- `busy` = OR of all tag valid bits | `res_valid`.
- Requesters must accept results unconditionally. There is no result backpressure.
- Reset (`reset=0` at an edge): all outputs are 0, `ptr=0`, and all tag valids are cleared.
  - Reset mid-operation drops in-flight products. No `res_valid` is produced for them.
  - During reset cycles, `gnt=0`.
- `en` falling mid-stream: ops already transferred complete normally. `en` does not affect `ptr`.

## Timing
- Transfer at edge k: `mul_ld`=1 during cycle k+1, `mul_p` valid in cycle k+1+LAT, `res_valid`=1 in cycle k+2+LAT.
- End-to-end latency is LAT+2 edges from transfer to result.
- Throughput: one transfer per cycle. A sole requester holding `req` is granted every cycle, back-to-back.
- Full contention (all `req` high): each requester is granted once every N_REQ cycles, in order ptr, ptr+1, ….
- Results emerge in issue order. Interleaved `res_id` follows the grant order exactly.
- Simultaneous transfer and result in the same cycle is normal and independent.
- Width rules:
  - `res_data` is the datapath's 16-bit signed result, passed unmodified.
  - Operand range is −128..127.
  - Full-range product −128×−128 = 16384 (0x4000) must be representable.

## Test plan
- Single requester 0, a=−3, b=5, LAT=3, transfer at edge 10: `mul_ld` high in cycle 11; `res_valid` in cycle 15 with `res_id=0`, `res_data=0xFFF1`.
- All four requesters request on the same cycle after reset: grants are 0,1,2,3 on consecutive edges. Results 127×−128=0xC080, −128×−128=0x4000, 0×55=0x0000, 7×9=0x003F return with IDs 0,1,2,3 on consecutive cycles.
- Requester 2 holds `req` for 6 cycles alone: 6 back-to-back transfers and 6 consecutive `res_valid` pulses, all with `res_id=2`.
- `en`=0 for 3 cycles while `req`=4'b1111 and two ops are in flight: `gnt`=0 throughout, both in-flight results still appear, and granting resumes at the unchanged `ptr`.
- `reset` low for one cycle two edges after a transfer: no `res_valid` for that op, `busy`=0, and the next grant goes to the lowest-index active `req` (`ptr`=0).
- Random `req`/operands over 10k cycles: a scoreboard checks every result against a*b, checks ID order, checks `gnt` is one-hot or zero, and checks no requester waits more than N_REQ−1 grants.
